// File: rtl/correlation_pkg.sv
// correlation_pkg: width and level helpers shared by the correlator and its adder tree
package correlation_pkg;
  function automatic int clog2(input int v);
    int r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
  function automatic int add_st(input int taps);
    return clog2(taps);
  endfunction
  function automatic int out_w(input int dw, input int taps);
    return 2 * dw + clog2(taps);
  endfunction
  function automatic int lvl_cnt(input int n, input int l);
    return (n + (1 << l) - 1) >> l;
  endfunction
  localparam int TAPS_DEF = 10;
  localparam int ADD_ST_DEF = add_st(TAPS_DEF);
endpackage

// File: rtl/corr_adder_tree.sv
// corr_adder_tree: pipelined pairwise sum of N signed products with a riding valid tag
module corr_adder_tree
  import correlation_pkg::*;
#(
  parameter int N = 10,
  parameter int IN_W = 9,
  parameter int OUT_W = 12
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 clear_i,
  input  logic                 en_i,
  input  logic                 tag_i,
  input  logic [N-1:0][IN_W-1:0] d_i,
  output logic [OUT_W-1:0]     sum_o,
  output logic                 tag_o
);
  localparam int L = add_st(N);
  localparam int M = 2 * N;
  logic [OUT_W-1:0] s_q [L+1][M];
  logic [OUT_W-1:0] s_d [L+1][M];
  logic [OUT_W-1:0] cur [L+1][M];
  logic [L:1] t_q;
  logic [L:0] tv;
  assign tv = {t_q, tag_i};
  always_comb begin
    cur = s_q;
    for (int i = 0; i < N; i++) cur[0][i] = OUT_W'($signed(d_i[i]));
    s_d = s_q;
    for (int l = 1; l <= L; l++)
      for (int i = 0; i < N; i++)
        if (2 * i + 1 < lvl_cnt(N, l - 1)) s_d[l][i] = cur[l-1][2*i] + cur[l-1][2*i+1];
        else if (2 * i < lvl_cnt(N, l - 1)) s_d[l][i] = cur[l-1][2*i];
    // the output register keeps its last result across untagged slots
    if (!tv[L-1]) s_d[L][0] = s_q[L][0];
  end
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) begin
      s_q <= '{default: '0};
      t_q <= '0;
    end else if (clear_i) begin
      s_q <= '{default: '0};
      t_q <= '0;
    end else if (en_i) begin
      s_q <= s_d;
      t_q <= tv[L-1:0];
    end
  assign sum_o = s_q[L][0];
  assign tag_o = t_q[L];
endmodule

// File: rtl/correlation_stream.sv
// correlation_stream: sliding-window dot product against a writable coefficient bank,
// valid/ready on both sides with a global stall
module correlation_stream
  import correlation_pkg::*;
#(
  parameter int TAPS = 10,
  parameter int DATA_W = 4,
  localparam int OUT_W = out_w(DATA_W, TAPS),
  localparam int AW = clog2(TAPS)
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] x_in_i,
  input  logic              x_valid_i,
  output logic              x_ready_o,
  input  logic              mode_signed_i,
  input  logic              coef_we_i,
  input  logic [AW-1:0]     coef_addr_i,
  input  logic [DATA_W-1:0] coef_data_i,
  output logic [OUT_W-1:0]  y_o,
  output logic              y_valid_o,
  input  logic              y_ready_i
);
  localparam int PW = 2 * DATA_W + 1;
  localparam int FW = clog2(TAPS + 1);
  logic [DATA_W-1:0] w_q [TAPS];
  logic [DATA_W-1:0] h_q [TAPS];
  logic [TAPS-1:0][PW-1:0] p_q, p_d;
  logic [FW-1:0] fill_q, fill_d;
  logic wt_q, wm_q, pt_q, advance, accept;
  // one extra bit keeps unsigned 15*15 and signed -8*-8 both representable
  function automatic logic [PW-1:0] mul(input logic s, input logic [DATA_W-1:0] a, b);
    logic signed [DATA_W:0] sa, sb;
    logic signed [2*DATA_W+1:0] m;
    sa = {s & a[DATA_W-1], a};
    sb = {s & b[DATA_W-1], b};
    m = sa * sb;
    return m[PW-1:0];
  endfunction
  assign advance = !y_valid_o || y_ready_i;
  assign x_ready_o = advance && !reset_i && !clear_i;
  assign accept = x_valid_i && x_ready_o;
  assign fill_d = (fill_q == FW'(TAPS)) ? fill_q : fill_q + 1'b1;
  always_comb begin
    p_d = '0;
    for (int k = 0; k < TAPS; k++) p_d[k] = mul(wm_q, w_q[k], h_q[k]);
  end
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) begin
      w_q <= '{default: '0};
      fill_q <= '0;
      wt_q <= 1'b0;
      wm_q <= 1'b0;
      p_q <= '0;
      pt_q <= 1'b0;
    end else if (clear_i) begin
      w_q <= '{default: '0};
      fill_q <= '0;
      wt_q <= 1'b0;
      wm_q <= 1'b0;
      p_q <= '0;
      pt_q <= 1'b0;
    end else if (advance) begin
      if (accept) begin
        w_q[0] <= x_in_i;
        for (int k = 1; k < TAPS; k++) w_q[k] <= w_q[k-1];
        fill_q <= fill_d;
        wm_q <= mode_signed_i;
      end
      wt_q <= accept && fill_d == FW'(TAPS);
      p_q <= p_d;
      pt_q <= wt_q;
    end
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) h_q <= '{default: '0};
    else if (coef_we_i && 32'(coef_addr_i) < TAPS) h_q[coef_addr_i] <= coef_data_i;
  corr_adder_tree #(.N(TAPS), .IN_W(PW), .OUT_W(OUT_W)) u_tree (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .clear_i (clear_i),
    .en_i    (advance),
    .tag_i   (pt_q),
    .d_i     (p_q),
    .sum_o   (y_o),
    .tag_o   (y_valid_o)
  );
endmodule

// File: tb/tb_correlation_stream.sv
// tb_correlation_stream: directed and random streams checked against a sample-history model
module tb_correlation_stream;
  localparam int TAPS = 10;
  localparam int DW = 4;
  localparam int OW = 12;
  localparam int AW = 4;
  logic clock_i = 1'b0;
  logic reset_i, clear_i, x_valid_i, x_ready_o, mode_signed_i, coef_we_i, y_valid_o, y_ready_i;
  logic [DW-1:0] x_in_i, coef_data_i;
  logic [AW-1:0] coef_addr_i;
  logic [OW-1:0] y_o;
  int checks = 0, passed = 0;
  int hm[TAPS];
  int hist[$];
  int expq[$];
  int fillm = 0;
  bit pv = 0, pm = 0;
  int pw[TAPS];
  bit a;
  int hold;

  correlation_stream dut (
    .clock_i(clock_i), .reset_i(reset_i), .clear_i(clear_i), .x_in_i(x_in_i),
    .x_valid_i(x_valid_i), .x_ready_o(x_ready_o), .mode_signed_i(mode_signed_i),
    .coef_we_i(coef_we_i), .coef_addr_i(coef_addr_i), .coef_data_i(coef_data_i),
    .y_o(y_o), .y_valid_o(y_valid_o), .y_ready_i(y_ready_i)
  );

  always #5 clock_i = ~clock_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
  endtask

  function automatic int sv(input int v, input bit s);
    return (s && v >= 8) ? v - 16 : v;
  endfunction

  function automatic int dot();
    int s = 0;
    for (int k = 0; k < TAPS; k++) s += sv(hm[k], pm) * sv(pw[k], pm);
    return s & 32'hFFF;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < TAPS; k++) hm[k] = 0;
    hist.delete();
    expq.delete();
    fillm = 0;
    pv = 0;
  endtask

  // called at edge+1 with inputs driven; returns at the following edge+1
  task automatic tick(output bit acc);
    bit adv;
    #3;
    acc = x_valid_i && x_ready_o;
    adv = !y_valid_o || y_ready_i;
    if (y_valid_o && y_ready_i) begin
      chk("y_pending", int'(expq.size() != 0), 1);
      if (expq.size() != 0) chk("y", y_o, expq.pop_front());
    end
    @(posedge clock_i);
    if (clear_i) begin
      hist.delete();
      expq.delete();
      fillm = 0;
      pv = 0;
    end else if (adv && pv) begin
      expq.push_back(dot());
      pv = 0;
    end
    if (coef_we_i && coef_addr_i < TAPS) hm[coef_addr_i] = coef_data_i;
    if (acc) begin
      hist.push_front(x_in_i);
      if (hist.size() > TAPS) void'(hist.pop_back());
      if (fillm < TAPS) fillm++;
      if (fillm == TAPS) begin
        pv = 1;
        pm = mode_signed_i;
        for (int k = 0; k < TAPS; k++) pw[k] = hist[k];
      end
    end
    #1;
  endtask

  task automatic send(input int x, input bit m);
    bit ok = 0;
    x_valid_i = 1;
    x_in_i = 4'(x);
    mode_signed_i = m;
    for (int n = 0; n < 20 && !ok; n++) tick(ok);
    chk("accept", ok, 1);
    x_valid_i = 0;
  endtask

  task automatic setc(input int ad, input int d);
    bit t;
    coef_we_i = 1;
    coef_addr_i = 4'(ad);
    coef_data_i = 4'(d);
    tick(t);
    coef_we_i = 0;
  endtask

  task automatic drain();
    bit t;
    x_valid_i = 0;
    y_ready_i = 1;
    repeat (8) tick(t);
    chk("drained", expq.size(), 0);
  endtask

  task automatic do_clear();
    bit t;
    clear_i = 1;
    tick(t);
    clear_i = 0;
  endtask

  initial begin
    reset_i = 1; clear_i = 0; x_valid_i = 0; x_in_i = 0; mode_signed_i = 0;
    coef_we_i = 0; coef_addr_i = 0; coef_data_i = 0; y_ready_i = 1;
    model_reset();
    @(posedge clock_i);
    #1;
    chk("rst_y", y_o, 0);
    chk("rst_vld", y_valid_o, 0);
    chk("rst_xrdy", x_ready_o, 0);
    reset_i = 0;

    // ramp through all-ones coefficients: latency and one result per cycle
    for (int k = 0; k < TAPS; k++) setc(k, 1);
    for (int x = 1; x <= 10; x++) send(x, 0);
    for (int x = 11; x <= 14; x++) begin
      send(x, 0);
      chk("lat_early", y_valid_o, 0);
    end
    send(15, 0);
    chk("lat_vld", y_valid_o, 1);
    chk("lat_y", y_o, 55);
    drain();
    chk("ramp_last", y_o, 105);

    do_clear();
    for (int k = 0; k < TAPS; k++) setc(k, 15);
    repeat (10) send(15, 0);
    drain();
    chk("umax", y_o, 12'h8CA);

    do_clear();
    for (int k = 0; k < TAPS; k++) setc(k, 8);
    repeat (10) send(8, 1);
    drain();
    chk("smax", y_o, 640);
    repeat (10) send(7, 1);
    drain();
    chk("smin", y_o, 12'hDD0);

    // stall with results pending
    do_clear();
    for (int k = 0; k < TAPS; k++) setc(k, $urandom_range(0, 15));
    repeat (10) send($urandom_range(0, 15), 0);
    for (int n = 0; n < 8 && !y_valid_o; n++) send($urandom_range(0, 15), 0);
    chk("stall_vld", y_valid_o, 1);
    y_ready_i = 0;
    x_valid_i = 1;
    x_in_i = 4'($urandom_range(0, 15));
    repeat (3) begin
      tick(a);
      chk("stall_y", y_o, expq[0]);
      chk("stall_hold", y_valid_o, 1);
      chk("stall_xrdy", x_ready_o, 0);
    end
    y_ready_i = 1;
    x_valid_i = 0;
    repeat (3) send($urandom_range(0, 15), $urandom_range(0, 1));
    drain();

    // clear in mid-stream keeps coefficients and restarts fill
    do_clear();
    for (int k = 0; k < TAPS; k++) setc(k, $urandom_range(0, 15));
    repeat (12) send($urandom_range(0, 15), 1);
    do_clear();
    chk("clr_vld", y_valid_o, 0);
    chk("clr_y", y_o, 0);
    repeat (9) send($urandom_range(0, 15), 1);
    drain();
    chk("clr_fill_vld", y_valid_o, 0);
    send($urandom_range(0, 15), 1);
    drain();

    // coefficient writes during streaming, out-of-range address, async reset
    do_clear();
    for (int k = 0; k < TAPS; k++) setc(k, 1);
    repeat (11) send($urandom_range(1, 15), 0);
    coef_we_i = 1; coef_addr_i = 4'd10; coef_data_i = 4'd15;
    send($urandom_range(1, 15), 0);
    coef_addr_i = 4'd3; coef_data_i = 4'd2;
    send($urandom_range(1, 15), 0);
    coef_we_i = 0;
    repeat (3) send($urandom_range(1, 15), 0);
    tick(a);
    #2 reset_i = 1;
    #1;
    chk("arst_y", y_o, 0);
    chk("arst_vld", y_valid_o, 0);
    chk("arst_xrdy", x_ready_o, 0);
    model_reset();
    @(posedge clock_i);
    #1;
    reset_i = 0;
    repeat (10) send($urandom_range(0, 15), 0);
    drain();
    chk("post_rst_y", y_o, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
